// File: rtl/rv_plic_gw_pkg.sv
// ----------------------------------------------------------------------------
// rv_plic_gw_pkg
// Shared types and defaults for the PLIC interrupt gateway.
//   - default source count, synchronizer depth and edge-counter width
//   - trigger mode enum (level / rising edge)
//   - packed per-source state {ip, ia, cnt}
//   - saturating counter update helper
// ----------------------------------------------------------------------------
package rv_plic_gw_pkg;

   localparam int N_SOURCE_DEF    = 37;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int CNT_W_DEF       = 2;

   // Storage width of the edge counter field. The live range is limited to
   // 2**CNT_W-1 by saturation, so bits above CNT_W always stay zero.
   localparam int CNT_W_MAX       = 8;

   typedef enum logic {
      TRIG_LEVEL = 1'b0,
      TRIG_EDGE  = 1'b1
   } trig_mode_e;

   typedef struct packed {
      logic                 ip;   // pending, presented to the arbiter
      logic                 ia;   // in service: claimed, not yet completed
      logic [CNT_W_MAX-1:0] cnt;  // edges seen but not yet turned into ip
   } gw_state_t;

   // cnt + inc - dec, clamped to [0, max].
   function automatic logic [CNT_W_MAX-1:0] cnt_update(
      input logic [CNT_W_MAX-1:0] cnt,
      input logic                 inc,
      input logic                 dec,
      input int                   max
   );
      int tmp;
      tmp = int'(cnt) + int'(inc) - int'(dec);
      if (tmp < 0)   tmp = 0;
      if (tmp > max) tmp = max;
      return CNT_W_MAX'(tmp);
   endfunction

endpackage

// File: rtl/rv_plic_gw_src.sv
// ----------------------------------------------------------------------------
// rv_plic_gw_src
// One interrupt source slice of the PLIC gateway: input synchronizer, rising
// edge detect, saturating edge counter, and the pending / in-service flops.
//   clk_i       clock
//   rst_i       asynchronous active-high reset
//   src_i       raw interrupt line (asynchronous to clk_i)
//   le_i        trigger mode: 1 = rising edge, 0 = level high
//   claim_i     claim pulse for this source
//   complete_i  complete pulse for this source
//   ip_o        registered pending bit
//   ia_o        registered in-service bit
// ----------------------------------------------------------------------------
module rv_plic_gw_src
   import rv_plic_gw_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic src_i,
   input  logic le_i,
   input  logic claim_i,
   input  logic complete_i,
   output logic ip_o,
   output logic ia_o
);

   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   s_q;
   gw_state_t              state_q;
   gw_state_t              state_d;
   trig_mode_e             mode;
   logic                   rise;
   logic                   elig;
   logic                   consume;
   logic                   set_level;

   assign s    = sync_q[SYNC_STAGES-1];
   assign mode = trig_mode_e'(le_i);

   // NOTE: every flop here is updated with <= so that all stages sample the
   // values from before the clock edge; blocking assignments would let the
   // synchronizer collapse into a single stage in simulation.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q  <= '0;
         s_q     <= 1'b0;
         state_q <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], src_i};
         s_q     <= s;
         state_q <= state_d;
      end
   end

   assign rise      = s & ~s_q;
   assign elig      = ~state_q.ip & ~state_q.ia;
   assign set_level = (mode == TRIG_LEVEL) & elig & s;
   // An edge event is either the edge arriving now or one counted earlier.
   assign consume   = (mode == TRIG_EDGE) & elig & (rise | (|state_q.cnt));

   // NOTE: state_d takes the full current state first, so any field not
   // explicitly updated below holds its value instead of inferring a latch.
   always_comb begin
      state_d = state_q;

      // Leaving edge mode discards counted edges; level mode keeps cnt at 0.
      if (mode == TRIG_EDGE) begin
         state_d.cnt = cnt_update(state_q.cnt, rise, consume, CNT_MAX);
      end else begin
         state_d.cnt = '0;
      end

      // ip and ia are never both set, so a claim against a pending request
      // and a complete against an in-service one cannot coincide; claim is
      // checked first so that it wins when both pulses arrive together.
      if (claim_i && state_q.ip) begin
         state_d.ip = 1'b0;
         state_d.ia = 1'b1;
      end else begin
         if (complete_i && state_q.ia) begin
            state_d.ia = 1'b0;
         end
         if (set_level || consume) begin
            state_d.ip = 1'b1;
         end
      end
   end

   assign ip_o = state_q.ip;
   assign ia_o = state_q.ia;

endmodule

// File: rtl/rv_plic_gateway.sv
// ----------------------------------------------------------------------------
// rv_plic_gateway
// Interrupt gateway in front of the PLIC priority/threshold arbiter. Turns
// raw asynchronous interrupt lines into registered pending bits and enforces
// one outstanding request per source through the claim/complete handshake.
// Requires N_SOURCE >= 2 and SYNC_STAGES >= 2.
//   clk_i       clock
//   rst_i       asynchronous active-high reset
//   src_i       [N_SOURCE] raw interrupt lines
//   le_i        [N_SOURCE] trigger mode per source (1 = edge, 0 = level)
//   claim_i     [N_SOURCE] one-hot claim pulse from the register block
//   complete_i  [N_SOURCE] complete pulse from the register block
//   ip_o        [N_SOURCE] pending bits to the arbiter
//   ia_o        [N_SOURCE] in-service bits
// ----------------------------------------------------------------------------
module rv_plic_gateway
   import rv_plic_gw_pkg::*;
#(
   parameter int N_SOURCE    = N_SOURCE_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [N_SOURCE-1:0] src_i,
   input  logic [N_SOURCE-1:0] le_i,
   input  logic [N_SOURCE-1:0] claim_i,
   input  logic [N_SOURCE-1:0] complete_i,
   output logic [N_SOURCE-1:0] ip_o,
   output logic [N_SOURCE-1:0] ia_o
);

   for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
      rv_plic_gw_src #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_W       (CNT_W)
      ) u_src (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .src_i      (src_i[i]),
         .le_i       (le_i[i]),
         .claim_i    (claim_i[i]),
         .complete_i (complete_i[i]),
         .ip_o       (ip_o[i]),
         .ia_o       (ia_o[i])
      );
   end

endmodule
